// File: rtl/elevator_request_regs_if.sv
// Button, clear and floor inputs plus request/summary outputs of the elevator request registers.
interface elevator_request_regs_if #(
  parameter int FLOORS  = 8,
  parameter int FLOOR_W = 3
);
  logic [FLOORS-1:0]  btn_in;
  logic [FLOORS-1:0]  btn_up;
  logic [FLOORS-1:0]  btn_down;
  logic [FLOORS-1:0]  block_mask;
  logic [FLOORS-1:0]  clr_in;
  logic [FLOORS-1:0]  clr_up;
  logic [FLOORS-1:0]  clr_down;
  logic [FLOOR_W-1:0] current_floor;
  logic [FLOORS-1:0]  active_in;
  logic [FLOORS-1:0]  active_up;
  logic [FLOORS-1:0]  active_down;
  logic               req_above;
  logic               req_below;
  logic               req_here;
  logic [FLOOR_W:0]   pending_count;

  modport master (
    output btn_in, btn_up, btn_down, block_mask, clr_in, clr_up, clr_down, current_floor,
    input  active_in, active_up, active_down, req_above, req_below, req_here, pending_count
  );

  modport slave (
    input  btn_in, btn_up, btn_down, block_mask, clr_in, clr_up, clr_down, current_floor,
    output active_in, active_up, active_down, req_above, req_below, req_here, pending_count
  );
endinterface

// File: rtl/elevator_request_regs.sv
// Synchronised, debounced cabin/hall request registers with registered direction summaries.
// Raw press to active bit: DEBOUNCE_CYCLES+3 edges, summaries one edge later; no backpressure.
module elevator_request_regs #(
  parameter int FLOORS          = 8,
  parameter int FLOOR_W         = 3,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic                   clk,
  input logic                   reset,
  elevator_request_regs_if.slave bus
);
  localparam int NB    = 3 * FLOORS;
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [FLOOR_W:0]  PC_ONE   = (FLOOR_W + 1)'(1);
  localparam logic [FLOORS-1:0] UP_OK    = {1'b0, {(FLOORS - 1){1'b1}}};
  localparam logic [FLOORS-1:0] DOWN_OK  = {{(FLOORS - 1){1'b1}}, 1'b0};

  logic [NB-1:0]      raw;
  logic [NB-1:0]      sync1;
  logic [NB-1:0]      sync2;
  logic [NB-1:0]      level;
  logic [NB-1:0]      press;
  logic [CNT_W-1:0]   cnt [NB];

  logic [FLOORS-1:0]  press_in;
  logic [FLOORS-1:0]  press_up;
  logic [FLOORS-1:0]  press_down;
  logic [FLOORS-1:0]  active_in;
  logic [FLOORS-1:0]  active_up;
  logic [FLOORS-1:0]  active_down;
  logic [FLOORS-1:0]  any;

  logic               above_c;
  logic               below_c;
  logic               here_c;
  logic [FLOOR_W:0]   count_c;
  logic               above_q;
  logic               below_q;
  logic               here_q;
  logic [FLOOR_W:0]   count_q;

  assign raw = {bus.btn_down, bus.btn_up, bus.btn_in};

  // Every button bit gets its own synchroniser, debounce counter and press pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      level <= '0;
      press <= '0;
      for (int i = 0; i < NB; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < NB; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] != level[i]) begin
          if (cnt[i] == CNT_LAST) begin
            level[i] <= sync2[i];
            press[i] <= sync2[i];
            cnt[i]   <= '0;
          end else begin
            cnt[i] <= cnt[i] + CNT_ONE;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  assign press_in   = press[FLOORS-1:0];
  assign press_up   = press[2*FLOORS-1:FLOORS];
  assign press_down = press[3*FLOORS-1:2*FLOORS];

  // Cabin: mask, then clear, then toggle. Hall: press wins over clear; end-floor bits never set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_in   <= '0;
      active_up   <= '0;
      active_down <= '0;
    end else begin
      active_in   <= (active_in ^ press_in) & ~bus.clr_in & ~bus.block_mask;
      active_up   <= ((active_up & ~bus.clr_up) | press_up) & UP_OK;
      active_down <= ((active_down & ~bus.clr_down) | press_down) & DOWN_OK;
    end
  end

  assign any = active_in | active_up | active_down;

  always_comb begin
    above_c = 1'b0;
    below_c = 1'b0;
    here_c  = 1'b0;
    count_c = '0;
    for (int i = 0; i < FLOORS; i++) begin
      if (any[i]) begin
        count_c = count_c + PC_ONE;
        // An out-of-range floor gives no direction, only the count.
        if (int'(bus.current_floor) < FLOORS) begin
          if (i > int'(bus.current_floor)) above_c = 1'b1;
          else if (i < int'(bus.current_floor)) below_c = 1'b1;
          else here_c = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      above_q <= 1'b0;
      below_q <= 1'b0;
      here_q  <= 1'b0;
      count_q <= '0;
    end else begin
      above_q <= above_c;
      below_q <= below_c;
      here_q  <= here_c;
      count_q <= count_c;
    end
  end

  assign bus.active_in     = active_in;
  assign bus.active_up     = active_up;
  assign bus.active_down   = active_down;
  assign bus.req_above     = above_q;
  assign bus.req_below     = below_q;
  assign bus.req_here      = here_q;
  assign bus.pending_count = count_q;
endmodule

// File: tb/tb_elevator_request_regs.sv
// Scenario bench for elevator_request_regs: expected snapshots are queued at stimulus time and
// popped against the DUT outputs once they are due.
module tb_elevator_request_regs;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_v;
  logic [31:0] obs_v;

  elevator_request_regs_if #(.FLOORS(8), .FLOOR_W(4)) bus ();

  elevator_request_regs #(.FLOORS(8), .FLOOR_W(4), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Snapshot layout: pending_count[4:0], {here, below, above}, down, up, cabin.
  function automatic logic [31:0] snap();
    return {bus.pending_count, bus.req_here, bus.req_below, bus.req_above,
            bus.active_down, bus.active_up, bus.active_in};
  endfunction

  function automatic logic [31:0] mk(input logic [4:0] pc, input logic [2:0] hba,
                                     input logic [7:0] dn, input logic [7:0] up,
                                     input logic [7:0] cab);
    return {pc, hba, dn, up, cab};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [7:0] cab, input logic [7:0] up, input logic [7:0] dn);
    bus.btn_in = cab;
    bus.btn_up = up;
    bus.btn_down = dn;
    tick(6);
    bus.btn_in = '0;
    bus.btn_up = '0;
    bus.btn_down = '0;
    tick(6);
  endtask

  task automatic test_reset();
    bus.btn_in = '1;
    bus.btn_up = '1;
    bus.btn_down = '1;
    tick(3);
    sb.push_back(mk(0, 0, 0, 0, 0));
    exp_v = sb.pop_front(); obs_v = snap(); checks++;
    if (obs_v !== exp_v) begin failures++; $display("FAIL reset_hold got=%h exp=%h", obs_v, exp_v); end
    bus.btn_in = '0;
    bus.btn_up = 8'h04;
    bus.btn_down = '0;
    reset = 1'b0;
    sb.push_back(mk(0, 0, 0, 0, 0));
    sb.push_back(mk(0, 0, 0, 8'h04, 0));
    sb.push_back(mk(1, 0, 0, 8'h04, 0));
    tick(6);
    exp_v = sb.pop_front(); obs_v = snap(); checks++;
    if (obs_v !== exp_v) begin failures++; $display("FAIL reset_release_e5 got=%h exp=%h", obs_v, exp_v); end
    tick(1);
    exp_v = sb.pop_front(); obs_v = snap(); checks++;
    if (obs_v !== exp_v) begin failures++; $display("FAIL reset_release_e6 got=%h exp=%h", obs_v, exp_v); end
    tick(1);
    exp_v = sb.pop_front(); obs_v = snap(); checks++;
    if (obs_v !== exp_v) begin failures++; $display("FAIL reset_release_pc got=%h exp=%h", obs_v, exp_v); end
    bus.btn_up = '0;
    tick(6);
    bus.clr_up = 8'h04;
    tick(1);
    bus.clr_up = '0;
    sb.push_back(mk(0, 0, 0, 0, 0));
    tick(1);
    exp_v = sb.pop_front(); obs_v = snap(); checks++;
    if (obs_v !== exp_v) begin failures++; $display("FAIL reset_clr_up got=%h exp=%h", obs_v, exp_v); end
  endtask

  task automatic test_debounce();
    bus.btn_in[3] = 1'b1;
    tick(3);
    bus.btn_in[3] = 1'b0;
    sb.push_back(mk(0, 0, 0, 0, 0));
    tick(10);
    exp_v = sb.pop_front(); obs_v = snap(); checks++;
    if (obs_v !== exp_v) begin failures++; $display("FAIL deb_glitch got=%h exp=%h", obs_v, exp_v); end
    bus.btn_in[3] = 1'b1;
    sb.push_back(mk(0, 0, 0, 0, 0));
    sb.push_back(mk(0, 0, 0, 0, 8'h08));
    sb.push_back(mk(1, 0, 0, 0, 8'h08));
    tick(6);
    exp_v = sb.pop_front(); obs_v = snap(); checks++;
    if (obs_v !== exp_v) begin failures++; $display("FAIL deb_e5 got=%h exp=%h", obs_v, exp_v); end
    tick(1);
    exp_v = sb.pop_front(); obs_v = snap(); checks++;
    if (obs_v !== exp_v) begin failures++; $display("FAIL deb_e6 got=%h exp=%h", obs_v, exp_v); end
    bus.btn_in[3] = 1'b0;
    tick(8);
    exp_v = sb.pop_front(); obs_v = snap(); checks++;
    if (obs_v !== exp_v) begin failures++; $display("FAIL deb_hold got=%h exp=%h", obs_v, exp_v); end
  endtask

  task automatic test_cabin();
    bus.clr_in = 8'h08;
    tick(1);
    bus.clr_in = '0;
    sb.push_back(mk(0, 0, 0, 0, 0));
    tick(1);
    exp_v = sb.pop_front(); obs_v = snap(); checks++;
    if (obs_v !== exp_v) begin failures++; $display("FAIL cab_clr got=%h exp=%h", obs_v, exp_v); end
    sb.push_back(mk(1, 0, 0, 0, 8'h20));
    press(8'h20, 0, 0);
    exp_v = sb.pop_front(); obs_v = snap(); checks++;
    if (obs_v !== exp_v) begin failures++; $display("FAIL cab_set got=%h exp=%h", obs_v, exp_v); end
    sb.push_back(mk(0, 0, 0, 0, 0));
    press(8'h20, 0, 0);
    exp_v = sb.pop_front(); obs_v = snap(); checks++;
    if (obs_v !== exp_v) begin failures++; $display("FAIL cab_toggle_off got=%h exp=%h", obs_v, exp_v); end
    sb.push_back(mk(0, 0, 0, 0, 0));
    bus.btn_in = 8'h20;
    tick(6);
    bus.clr_in = 8'h20;
    tick(1);
    bus.clr_in = '0;
    exp_v = sb.pop_front(); obs_v = snap(); checks++;
    if (obs_v !== exp_v) begin failures++; $display("FAIL cab_clr_beats_press got=%h exp=%h", obs_v, exp_v); end
    bus.btn_in = '0;
    tick(6);
    sb.push_back(mk(1, 0, 0, 0, 8'h20));
    press(8'h20, 0, 0);
    exp_v = sb.pop_front(); obs_v = snap(); checks++;
    if (obs_v !== exp_v) begin failures++; $display("FAIL cab_set_again got=%h exp=%h", obs_v, exp_v); end
    bus.block_mask = 8'h20;
    sb.push_back(mk(1, 0, 0, 0, 0));
    tick(1);
    exp_v = sb.pop_front(); obs_v = snap(); checks++;
    if (obs_v !== exp_v) begin failures++; $display("FAIL cab_block got=%h exp=%h", obs_v, exp_v); end
    sb.push_back(mk(0, 0, 0, 0, 0));
    press(8'h20, 0, 0);
    exp_v = sb.pop_front(); obs_v = snap(); checks++;
    if (obs_v !== exp_v) begin failures++; $display("FAIL cab_block_press got=%h exp=%h", obs_v, exp_v); end
    bus.block_mask = '0;
  endtask

  task automatic test_hall();
    sb.push_back(mk(0, 0, 0, 8'h02, 0));
    bus.btn_up = 8'h02;
    tick(6);
    bus.clr_up = 8'h02;
    tick(1);
    bus.clr_up = '0;
    exp_v = sb.pop_front(); obs_v = snap(); checks++;
    if (obs_v !== exp_v) begin failures++; $display("FAIL hall_press_beats_clr got=%h exp=%h", obs_v, exp_v); end
    bus.btn_up = '0;
    sb.push_back(mk(1, 0, 0, 8'h02, 0));
    tick(6);
    exp_v = sb.pop_front(); obs_v = snap(); checks++;
    if (obs_v !== exp_v) begin failures++; $display("FAIL hall_settled got=%h exp=%h", obs_v, exp_v); end
    sb.push_back(mk(1, 0, 0, 0, 0));
    bus.clr_up = 8'h02;
    tick(1);
    bus.clr_up = '0;
    exp_v = sb.pop_front(); obs_v = snap(); checks++;
    if (obs_v !== exp_v) begin failures++; $display("FAIL hall_clr got=%h exp=%h", obs_v, exp_v); end
    tick(1);
    sb.push_back(mk(0, 0, 0, 0, 0));
    press(0, 8'h80, 8'h01);
    exp_v = sb.pop_front(); obs_v = snap(); checks++;
    if (obs_v !== exp_v) begin failures++; $display("FAIL hall_boundary got=%h exp=%h", obs_v, exp_v); end
  endtask

  task automatic test_summary();
    bus.current_floor = 4'd4;
    sb.push_back(mk(2, 3'b011, 8'h02, 0, 8'h40));
    press(8'h40, 0, 8'h02);
    exp_v = sb.pop_front(); obs_v = snap(); checks++;
    if (obs_v !== exp_v) begin failures++; $display("FAIL sum_floor4 got=%h exp=%h", obs_v, exp_v); end
    bus.current_floor = 4'd6;
    sb.push_back(mk(2, 3'b110, 8'h02, 0, 8'h40));
    tick(1);
    exp_v = sb.pop_front(); obs_v = snap(); checks++;
    if (obs_v !== exp_v) begin failures++; $display("FAIL sum_floor6 got=%h exp=%h", obs_v, exp_v); end
    bus.current_floor = 4'd9;
    sb.push_back(mk(2, 3'b000, 8'h02, 0, 8'h40));
    tick(1);
    exp_v = sb.pop_front(); obs_v = snap(); checks++;
    if (obs_v !== exp_v) begin failures++; $display("FAIL sum_floor9 got=%h exp=%h", obs_v, exp_v); end
    bus.current_floor = 4'd1;
    sb.push_back(mk(2, 3'b101, 8'h02, 0, 8'h40));
    tick(1);
    exp_v = sb.pop_front(); obs_v = snap(); checks++;
    if (obs_v !== exp_v) begin failures++; $display("FAIL sum_floor1 got=%h exp=%h", obs_v, exp_v); end
    bus.current_floor = 4'd15;
    tick(1);
  endtask

  task automatic test_back_to_back();
    sb.push_back(mk(8, 0, 8'hFE, 8'h7F, 8'hBF));
    press(8'hFF, 8'hFF, 8'hFF);
    exp_v = sb.pop_front(); obs_v = snap(); checks++;
    if (obs_v !== exp_v) begin failures++; $display("FAIL all_floors got=%h exp=%h", obs_v, exp_v); end
  endtask

  task automatic test_async_reset();
    bus.btn_in = 8'h01;
    tick(3);
    #2;
    reset = 1'b1;
    sb.push_back(mk(0, 0, 0, 0, 0));
    #1;
    exp_v = sb.pop_front(); obs_v = snap(); checks++;
    if (obs_v !== exp_v) begin failures++; $display("FAIL async_immediate got=%h exp=%h", obs_v, exp_v); end
    bus.btn_in = '0;
    tick(2);
    reset = 1'b0;
    sb.push_back(mk(0, 0, 0, 0, 0));
    tick(12);
    exp_v = sb.pop_front(); obs_v = snap(); checks++;
    if (obs_v !== exp_v) begin failures++; $display("FAIL async_no_stale got=%h exp=%h", obs_v, exp_v); end
  endtask

  initial begin
    bus.btn_in = '0;
    bus.btn_up = '0;
    bus.btn_down = '0;
    bus.block_mask = '0;
    bus.clr_in = '0;
    bus.clr_up = '0;
    bus.clr_down = '0;
    bus.current_floor = 4'd15;
    #2;
    reset = 1'b1;
    test_reset();
    test_debounce();
    test_cabin();
    test_hall();
    test_summary();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
